// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the register bank reader and its storage.
package reg_bank_pkg;

    localparam int DATA_W           = 8;
    localparam int DEFAULT_NUM_REGS = 8;
    localparam int DEFAULT_AW       = 3;

    typedef enum logic {
        ST_IDLE,
        ST_DUMP
    } state_t;

    // Smallest address width (at least 1) that can index numRegs entries.
    function automatic int calcAw(input int numRegs);
        int w;
        w = 1;
        while ((1 << w) < numRegs) w++;
        return w;
    endfunction

endpackage

// File: rtl/reg_bank_reader_if.sv
// Write port plus read request / response channel of the register bank reader.
// REG_BANK_READER_PARITY_EN adds the RspParity response bit.
interface reg_bank_reader_if
    import reg_bank_pkg::*;
#(
    parameter int AW = DEFAULT_AW
);

    logic              WriteEnable;
    logic [AW-1:0]     WrAddr;
    logic [DATA_W-1:0] D;
    logic              RdReqValid;
    logic              RdReqReady;
    logic [AW-1:0]     RdAddr;
    logic              DumpStart;
    logic              DumpBusy;
    logic              RspValid;
    logic              RspReady;
    logic [DATA_W-1:0] RspData;
    logic [AW-1:0]     RspAddr;
    logic              RspErr;
`ifdef REG_BANK_READER_PARITY_EN
    logic              RspParity;
`endif

    modport master (
        output WriteEnable, WrAddr, D, RdReqValid, RdAddr, DumpStart, RspReady,
        input  RdReqReady, DumpBusy, RspValid, RspData, RspAddr, RspErr
`ifdef REG_BANK_READER_PARITY_EN
        , input RspParity
`endif
    );

    modport slave (
        input  WriteEnable, WrAddr, D, RdReqValid, RdAddr, DumpStart, RspReady,
        output RdReqReady, DumpBusy, RspValid, RspData, RspAddr, RspErr
`ifdef REG_BANK_READER_PARITY_EN
        , output RspParity
`endif
    );

endinterface

// File: rtl/reg_bank_storage.sv
// Entry array with one write port and a combinational, write-first read mux.
module reg_bank_storage
    import reg_bank_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int AW       = calcAw(NUM_REGS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WriteEnable,
    input  logic [AW-1:0]     WrAddr,
    input  logic [DATA_W-1:0] D,
    input  logic [AW-1:0]     RdAddr,
    output logic [DATA_W-1:0] RdData,
    output logic              RdErr
);

    // One extra bit so NUM_REGS == 2**AW still fits in the bound.
    localparam logic [AW:0] LIMIT = (AW+1)'(NUM_REGS);

    logic [DATA_W-1:0] entries [NUM_REGS];
    logic              wrInRange;
    logic              rdInRange;

    assign wrInRange = {1'b0, WrAddr} < LIMIT;
    assign rdInRange = {1'b0, RdAddr} < LIMIT;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                entries[i] <= '0;
            end
        end else if (WriteEnable && wrInRange) begin
            entries[WrAddr] <= D;
        end
    end

    // A same-edge write to the addressed entry wins over the stored value.
    always_comb begin
        RdData = '0;
        RdErr  = !rdInRange;
        if (rdInRange) begin
            if (WriteEnable && (WrAddr == RdAddr)) begin
                RdData = D;
            end else begin
                RdData = entries[RdAddr];
            end
        end
    end

endmodule

// File: rtl/reg_bank_reader.sv
// Register bank with single-read and full-dump responder on a valid/ready channel.
// REG_BANK_READER_PARITY_EN registers even parity of the response data into RspParity.
module reg_bank_reader
    import reg_bank_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int AW       = calcAw(NUM_REGS)
) (
    input  logic           CLK,
    input  logic           RST,
    reg_bank_reader_if.slave bus
);

    state_t            state;
    state_t            nextState;
    logic [AW-1:0]     dumpIdx;
    logic [AW-1:0]     rdSel;
    logic [DATA_W-1:0] rdData;
    logic              rdErr;
    logic              slotFree;
    logic              slotLoad;
    logic              rdReady;
    logic              lastIdx;

    logic              rspValid;
    logic [DATA_W-1:0] rspData;
    logic [AW-1:0]     rspAddr;
    logic              rspErr;

    reg_bank_storage #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) storage (
        .CLK         (CLK),
        .RST         (RST),
        .WriteEnable (bus.WriteEnable),
        .WrAddr      (bus.WrAddr),
        .D           (bus.D),
        .RdAddr      (rdSel),
        .RdData      (rdData),
        .RdErr       (rdErr)
    );

    assign slotFree = !rspValid || bus.RspReady;
    assign lastIdx  = (dumpIdx == AW'(NUM_REGS - 1));

    // DumpStart takes priority over a same-cycle read request in IDLE.
    always_comb begin
        nextState = state;
        slotLoad  = 1'b0;
        rdReady   = 1'b0;
        rdSel     = bus.RdAddr;
        case (state)
            ST_IDLE: begin
                rdReady  = !RST && slotFree && !bus.DumpStart;
                slotLoad = bus.RdReqValid && rdReady;
                if (bus.DumpStart) begin
                    nextState = ST_DUMP;
                end
            end
            ST_DUMP: begin
                rdSel    = dumpIdx;
                slotLoad = slotFree;
                if (slotFree && lastIdx) begin
                    nextState = ST_IDLE;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dumpIdx <= '0;
        end else if (state == ST_IDLE) begin
            dumpIdx <= '0;
        end else if (slotLoad) begin
            dumpIdx <= dumpIdx + 1'b1;
        end
    end

    // The slot only changes on a load; otherwise a pending beat holds its payload.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rspValid <= 1'b0;
            rspData  <= '0;
            rspAddr  <= '0;
            rspErr   <= 1'b0;
        end else if (slotLoad) begin
            rspValid <= 1'b1;
            rspData  <= rdData;
            rspAddr  <= rdSel;
            rspErr   <= rdErr;
        end else if (bus.RspReady) begin
            rspValid <= 1'b0;
        end
    end

`ifdef REG_BANK_READER_PARITY_EN
    logic rspParity;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rspParity <= 1'b0;
        end else if (slotLoad) begin
            rspParity <= ^rdData;
        end
    end

    assign bus.RspParity = rspParity;
`endif

    assign bus.RdReqReady = rdReady;
    assign bus.DumpBusy   = (state == ST_DUMP);
    assign bus.RspValid   = rspValid;
    assign bus.RspData    = rspData;
    assign bus.RspAddr    = rspAddr;
    assign bus.RspErr     = rspErr;

endmodule

// File: doc/reg_bank_reader.md
Name: reg_bank_reader

Overview:
- Register bank of NUM_REGS x 8-bit entries.
- One write port with WriteEnable/address/data.
- A read responder returns entry contents over a valid/ready response channel, for single reads or a full-bank dump.
- Sits between the datapath's register writers and any consumer that must read register state back (debug, bus bridge, test logic).

Parameters:
- NUM_REGS, 8, number of 8-bit entries (2..256).
- AW, 3, address width; must satisfy 2**AW >= NUM_REGS.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-high; clears all state immediately.
- WriteEnable  in  1  write strobe.
- WrAddr  in  AW  write address.
- D  in  8  write data.
- RdReqValid  in  1  single-read request valid.
- RdReqReady  out  1  request accepted when high together with RdReqValid.
- RdAddr  in  AW  single-read address.
- DumpStart  in  1  one-cycle pulse; starts a full-bank dump.
- DumpBusy  out  1  high while a dump is in progress.
- RspValid  out  1  response valid.
- RspReady  in  1  consumer accepts the response.
- RspData  out  8  response data.
- RspAddr  out  AW  address the response belongs to.
- RspErr  out  1  high when the response address is >= NUM_REGS.

Behaviour:
- Reset (async, any time, including mid-dump or mid-handshake):
  - All entries = 0.
  - State = IDLE.
  - RspValid = 0, RspData = 0, RspAddr = 0, RspErr = 0, DumpBusy = 0, dump index = 0.
  - RdReqReady = 0 while RST is high.
- Write port:
  - On a rising edge with WriteEnable=1 and WrAddr<NUM_REGS, entry[WrAddr] <= D.
  - WrAddr >= NUM_REGS: write silently dropped.
  - Writes are accepted in every state and are independent of the read side.
- Output slot: a single response register. It is "free" when RspValid=0, or when RspValid=1 and RspReady=1 in that cycle.
- State machine:
  - IDLE:
    - RdReqReady = slot free AND DumpStart=0.
    - On RdReqValid & RdReqReady, the slot loads the response next edge with latency 1 cycle: RspAddr=RdAddr and RspValid=1.
    - DumpStart=1 in IDLE moves to DUMP next edge with index=0 and DumpBusy=1.
    - DumpStart has priority over a same-cycle RdReqValid; that request is not accepted.
  - DUMP:
    - RdReqReady=0.
    - Each cycle the slot is free, load entry[index] with RspAddr=index, then index++.
    - After loading index NUM_REGS-1, go to IDLE; DumpBusy falls on that same edge.
    - The last beat may still be pending in the slot after DumpBusy falls.
    - DumpStart is ignored while in DUMP.
- Throughput: 1 response per cycle when RspReady is held high. A full dump takes NUM_REGS cycles.
- Stability: while RspValid=1 and RspReady=0, RspData/RspAddr/RspErr hold constant. Later writes to that entry do not alter the pending response.
- Write-read bypass: if a load into the slot and a write to the same valid address occur on the same edge, RspData = D (write-first).
- Out-of-range single read (RdAddr >= NUM_REGS): the request is accepted normally; response has RspData=0, RspErr=1. RspErr is 0 otherwise.
- RspValid falls after the accepting edge unless the slot reloads on that same edge.

Optional Feature:
- Macro: REG_BANK_READER_PARITY_EN.
- When defined:
  - Adds output RspParity (1 bit) = even parity (XOR) of RspData.
  - It is registered with the slot, follows the same stability rule, and resets to 0.
  - An out-of-range response has RspParity=0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package reg_bank_pkg:
  - State enum {ST_IDLE, ST_DUMP}.
  - Constant DATA_W=8.
  - Default NUM_REGS/AW constants.
  - Function computing AW from NUM_REGS.
- Natural sub-module: reg_bank_storage. Holds the entry array, the write port, and the combinational read mux with write-first bypass. The top level holds the FSM, dump counter and output slot.

Test Plan:
- Reset then single read: write 0xA5 to addr 3; next cycle RdReqValid addr 3 with RspReady=1 -> RspValid 1 cycle later, RspData=0xA5, RspAddr=3, RspErr=0.
- Backpressure: RspReady=0 for 4 cycles with a pending read of addr 2 (0x11), writing 0x22 to addr 2 meanwhile -> RspData stays 0x11 and RdReqReady=0; RspReady=1 -> handshake completes, RdReqReady returns to 1.
- Bypass: same edge writes 0x7E to addr 5 and accepts a read of addr 5 -> RspData=0x7E.
- Dump: entries preloaded with 0x10..0x17, DumpStart pulse, RspReady=1 -> 8 consecutive beats with RspAddr 0..7 and data 0x10..0x17; DumpBusy high for exactly 8 cycles; a same-cycle RdReqValid is not accepted.
- Dump with RspReady toggling every other cycle -> no beat lost or duplicated; order preserved. Assert RST mid-dump (after beat 3) -> RspValid, DumpBusy and all entries are 0 immediately; state IDLE after release.
- NUM_REGS=6, AW=3: read addr 7 -> RspErr=1, RspData=0. Write to addr 6 -> dropped (a dump shows entries 0..5 only). With REG_BANK_READER_PARITY_EN, reading 0x07 -> RspParity=1.
